// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode circular instruction buffer with stall, flush and a NOP when empty.
module instr_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ValidF,
  input  logic [DATA_WIDTH-1:0]        InstrF,
  input  logic [ADDR_WIDTH-1:0]        PCF,
  output logic                         ReadyF,
  input  logic                         StallD,
  input  logic                         FlushD,
  output logic                         ValidD,
  output logic [DATA_WIDTH-1:0]        InstrD,
  output logic [ADDR_WIDTH-1:0]        PCD,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         AlmostFull
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    ReadyF = cnt_q != CW'(DEPTH);
    ValidD = cnt_q != '0;
    AlmostFull = cnt_q >= CW'(DEPTH-1);
    Count = cnt_q;
    InstrD = ValidD ? instr_q[rd_q] : NOP_INSTR;
    PCD = ValidD ? pc_q[rd_q] : '0;
    push = ValidF && ReadyF && !FlushD;
    pop = ValidD && !StallD && !FlushD;
    wr_d = FlushD ? '0 : push ? wr_q + PW'(1) : wr_q;
    rd_d = FlushD ? '0 : pop ? rd_q + PW'(1) : rd_q;
    cnt_d = FlushD ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // Payload storage is left uncleared; ValidD masks stale entries.
  always_ff @(posedge clk)
    if (push) begin
      instr_q[wr_q] <= InstrF;
      pc_q[wr_q] <= PCF;
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus checked against a queue-based model every cycle plus literal expectations.
module tb_instr_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic ValidF = 0, StallD = 0, FlushD = 0;
  logic [31:0] InstrF = 0, PCF = 0;
  logic ReadyF, ValidD, AlmostFull;
  logic [31:0] InstrD, PCD;
  logic [2:0] Count;
  int checks = 0, errors = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  entry_t q[$];

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .ReadyF(ReadyF),
    .StallD(StallD), .FlushD(FlushD), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .Count(Count), .AlmostFull(AlmostFull)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit p, o;
    if (rst) q.delete();
    else if (FlushD) q.delete();
    else begin
      p = ValidF && q.size() < DEPTH;
      o = q.size() > 0 && !StallD;
      if (o) void'(q.pop_front());
      if (p) q.push_back('{InstrF, PCF});
    end
  end

  always @(negedge clk) if (!rst) begin
    check("m_valid", ValidD, q.size() != 0);
    check("m_instr", InstrD, q.size() != 0 ? q[0].instr : 32'h13);
    check("m_pc", PCD, q.size() != 0 ? q[0].pc : 32'h0);
    check("m_count", Count, q.size());
    check("m_ready", ReadyF, q.size() != DEPTH);
    check("m_afull", AlmostFull, q.size() >= DEPTH - 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    StallD = 1;
    ValidF = 1;
    for (int i = 0; i < n; i++) begin
      InstrF = base + i;
      PCF = 32'h300 + 4 * i;
      tick();
    end
    ValidF = 0;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_count", Count, 0);
    check("rst_valid", ValidD, 0);
    check("rst_instr", InstrD, 32'h13);
    check("rst_ready", ReadyF, 1);
    check("rst_afull", AlmostFull, 0);
    StallD = 1;
    ValidF = 1;
    for (int i = 0; i < 4; i++) begin
      InstrF = 32'hA0 + i;
      PCF = 32'h100 + 4 * i;
      tick();
      check("fill_count", Count, i + 1);
      check("fill_afull", AlmostFull, i >= 2);
    end
    InstrF = 32'hEE;
    check("full_ready", ReadyF, 0);
    tick();
    check("full_ignored", Count, 4);
    ValidF = 0;
    StallD = 0;
    for (int i = 0; i < 4; i++) begin
      check("drain_instr", InstrD, 32'hA0 + i);
      check("drain_pc", PCD, 32'h100 + 4 * i);
      tick();
    end
    check("drain_empty", ValidD, 0);
    ValidF = 1;
    for (int i = 0; i < 10; i++) begin
      InstrF = 32'hC0 + i;
      PCF = 32'h200 + 4 * i;
      tick();
      check("stream_count", Count, 1);
      check("stream_instr", InstrD, 32'hC0 + i);
      check("stream_pc", PCD, 32'h200 + 4 * i);
    end
    ValidF = 0;
    tick();
    check("stream_end", Count, 0);
    fill(2, 32'hB0);
    check("pre_flush", Count, 2);
    FlushD = 1;
    ValidF = 1;
    InstrF = 32'hBB;
    check("flush_ready", ReadyF, 1);
    tick();
    FlushD = 0;
    ValidF = 0;
    check("flush_count", Count, 0);
    check("flush_valid", ValidD, 0);
    check("flush_instr", InstrD, 32'h13);
    tick();
    check("flush_nobb", InstrD, 32'h13);
    StallD = 1;
    ValidF = 1;
    InstrF = 32'h0050_0093;
    PCF = 32'h20;
    tick();
    ValidF = 0;
    for (int i = 0; i < 3; i++) begin
      check("hold_instr", InstrD, 32'h0050_0093);
      check("hold_pc", PCD, 32'h20);
      check("hold_valid", ValidD, 1);
      check("hold_count", Count, 1);
      tick();
    end
    StallD = 0;
    tick();
    check("hold_rel_valid", ValidD, 0);
    check("hold_rel_instr", InstrD, 32'h13);
    fill(4, 32'hD0);
    StallD = 0;
    ValidF = 1;
    InstrF = 32'hE0;
    PCF = 32'h400;
    check("fp_ready0", ReadyF, 0);
    tick();
    check("fp_count3", Count, 3);
    check("fp_ready1", ReadyF, 1);
    check("fp_head", InstrD, 32'hD1);
    tick();
    ValidF = 0;
    check("fp_accept", Count, 3);
    check("fp_head2", InstrD, 32'hD2);
    repeat (3) tick();
    check("fp_drained", Count, 0);
    fill(3, 32'hF0);
    #2 rst = 1;
    #1;
    check("arst_valid", ValidD, 0);
    check("arst_instr", InstrD, 32'h13);
    check("arst_pc", PCD, 0);
    check("arst_count", Count, 0);
    check("arst_ready", ReadyF, 1);
    tick();
    rst = 0;
    StallD = 0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
